regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//   Read-side debug engine for the 32x32 register file. On a start pulse it freezes the core,
//   walks register addresses FIRST_REG..NUM_REGS-1 through a dedicated combinational read port
//   and serialises each word into a byte stream with valid/ready handshake (feeds UART TX for
//   FPGA verification). Sits beside the register file, opposite the writeback write port.
// PARAMETERS
//   NUM_REGS   32     registers dumped are FIRST_REG..NUM_REGS-1 (NUM_REGS <= 32)
//   FIRST_REG  0      first register address dumped
//   SYNC_BYTE  8'hA5  header byte emitted before the first register
// PORTS
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous, active-high; sampled on posedge clk
//   start      in   1   1-cycle request to begin a dump; ignored while busy
//   rf_addr    out  5   read address to register file debug port
//   rf_data    in   32  combinational read data for rf_addr (x0 reads 0)
//   hold_cpu   out  1   stalls core (no RegWrite/PC update) while high
//   out_data   out  8   stream byte
//   out_valid  out  1   out_data valid
//   out_ready  in   1   sink accepts byte when out_valid & out_ready at posedge
//   busy       out  1   dump in progress
//   done       out  1   1-cycle pulse after final byte accepted
// BEHAVIOUR
//   Reset: state=IDLE; rf_addr=FIRST_REG; out_data=0; out_valid=0; hold_cpu=0; busy=0; done=0.
//     Reset has priority over every other input, including mid-dump: dump aborts with no done
//     pulse, and hold_cpu drops on the next edge.
//   FSM states IDLE, SYNC, FETCH, SEND, FIN:
//     IDLE : start=1 -> SYNC; hold_cpu=1 and busy=1 from the next cycle.
//     SYNC : out_valid=1, out_data=SYNC_BYTE; on accept -> FETCH, rf_addr=FIRST_REG.
//     FETCH: one cycle; latch rf_data into 32-bit shift reg; byte_cnt=0 -> SEND.
//       The one-cycle FETCH lets the frozen core's writeback settle before data is sampled.
//     SEND : out_valid=1, out_data=shift[7:0] (little-endian); on accept shift>>8, byte_cnt++.
//       Accept with byte_cnt==3:
//         - rf_addr==NUM_REGS-1 -> FIN
//         - otherwise rf_addr+1 -> FETCH
//     FIN  : done=1 for exactly one cycle; hold_cpu=0, busy=0 -> IDLE.
//   Handshake: out_data is stable and out_valid stays high until accepted; no combinational
//     path from out_ready to out_valid. Back-to-back accepts (out_ready held 1) give 1 byte/cycle
//     within a register, plus 1 FETCH bubble per register.
//   Counts:
//     - total bytes = 1 + 4*(NUM_REGS-FIRST_REG); 129 with defaults
//     - min latency start->done = 1 + 1 + 32*(1+4) + 1 cycles with out_ready tied high
//   start arriving in FIN or while busy: ignored; no queued request. start and reset together:
//     reset wins.
//   rf_addr counter is 5 bits; never wraps past NUM_REGS-1.
//   x0 is dumped as 32'h0 (the register file guarantees it).
// STRUCTURE
//   Shared package/defines: FSM state encodings (3-bit), SYNC_BYTE default, REG_ADDR_W=5,
//     XLEN=32, also used by the register file and core.
//   Single module; the byte serialiser (shift reg + 2-bit byte counter + valid/ready) is the
//     natural sub-module: word_byte_serializer. Optional; inline is acceptable.
// TESTING
//   1 Preload x1=32'h11223344, x2=32'h4000, rest 0; start, out_ready=1 -> bytes A5,
//     00 00 00 00, 44 33 22 11, 00 40 00 00, ...; 129 bytes total; done once.
//   2 out_ready toggled 1-0-1 pseudo-randomly -> identical byte sequence; out_data unchanged
//     while out_valid & !out_ready.
//   3 Reset asserted during SEND of x7 byte 2 -> next cycle out_valid=0, busy=0, hold_cpu=0;
//     no done; a new start gives a full dump beginning with A5.
//   4 start pulsed repeatedly during dump -> exactly one dump, one done pulse.
//   5 FIRST_REG=2, NUM_REGS=4 -> A5 then x2,x3 words; 9 bytes; done after 9th accept.
//   6 Core attempts RegWrite x5<=32'hDEADBEEF during dump -> hold_cpu=1 blocks it; dumped x5
//     is the pre-dump value.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file debug dump path, also used by the
// register file and core.
package regfile_dump_reader_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = XLEN / BYTE_W;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_FETCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_FIN   = 3'd4
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader_serializer.sv
// Word-to-byte serialiser: 32-bit shift register emitting the least significant
// byte first, with a byte counter flagging the last byte of the word.
module regfile_dump_reader_serializer
  import regfile_dump_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [XLEN-1:0]   i_word,
  input  logic              i_shift,
  output logic [BYTE_W-1:0] o_byte,
  output logic              o_last_c
);

  logic [XLEN-1:0]       r_shift;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (i_load) begin
      r_shift    <= i_word;
      r_byte_cnt <= '0;
    end else if (i_shift) begin
      r_shift    <= r_shift >> BYTE_W;
      r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
    end
  end

  assign o_byte   = r_shift[BYTE_W-1:0];
  assign o_last_c = (r_byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug dump engine: freezes the core, walks the register file read port and
// streams a sync byte followed by every word, little-endian, over valid/ready.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned       NUM_REGS  = 32,
  parameter int unsigned       FIRST_REG = 0,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [REG_ADDR_W-1:0] rf_addr,
  input  logic [XLEN-1:0]       rf_data,
  output logic                  hold_cpu,
  output logic [BYTE_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_ADDR_W-1:0] FIRST_ADDR = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_ADDR  = REG_ADDR_W'(NUM_REGS - 1);

  dump_state_e           r_state;
  dump_state_e           w_next_state;
  logic [REG_ADDR_W-1:0] r_rf_addr;
  logic                  r_out_valid;
  logic                  r_hold_cpu;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_load_sync;
  logic                  w_load_word;
  logic                  w_shift;
  logic                  w_addr_first;
  logic                  w_addr_inc;
  logic                  w_last_byte;
  logic [XLEN-1:0]       w_load_value;
  logic [BYTE_W-1:0]     w_ser_byte;

  assign w_accept = r_out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_next_state = r_state;
    w_load_sync  = 1'b0;
    w_load_word  = 1'b0;
    w_shift      = 1'b0;
    w_addr_first = 1'b0;
    w_addr_inc   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_SYNC;
          w_load_sync  = 1'b1;
        end
      end
      ST_SYNC: begin
        if (w_accept) begin
          w_next_state = ST_FETCH;
          w_shift      = 1'b1;
          w_addr_first = 1'b1;
        end
      end
      // Extra cycle lets the frozen core's last writeback land before sampling.
      ST_FETCH: begin
        w_next_state = ST_SEND;
        w_load_word  = 1'b1;
      end
      ST_SEND: begin
        if (w_accept) begin
          w_shift = 1'b1;
          if (w_last_byte) begin
            if (r_rf_addr == LAST_ADDR) begin
              w_next_state = ST_FIN;
            end else begin
              w_next_state = ST_FETCH;
              w_addr_inc   = 1'b1;
            end
          end
        end
      end
      ST_FIN: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rf_addr   <= FIRST_ADDR;
      r_out_valid <= 1'b0;
      r_hold_cpu  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_addr_first) begin
        r_rf_addr <= FIRST_ADDR;
      end else if (w_addr_inc) begin
        r_rf_addr <= r_rf_addr + REG_ADDR_W'(1);
      end
      r_out_valid <= (w_next_state == ST_SYNC) || (w_next_state == ST_SEND);
      r_hold_cpu  <= (w_next_state == ST_SYNC) || (w_next_state == ST_FETCH) ||
                     (w_next_state == ST_SEND);
      r_busy      <= (w_next_state == ST_SYNC) || (w_next_state == ST_FETCH) ||
                     (w_next_state == ST_SEND);
      r_done      <= (w_next_state == ST_FIN);
    end
  end

  // Sync byte goes through the shift register so out_data is always a flop
  assign w_load_value = w_load_sync ? XLEN'(SYNC_BYTE) : rf_data;

  regfile_dump_reader_serializer u_serializer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load_sync | w_load_word),
    .i_word   (w_load_value),
    .i_shift  (w_shift),
    .o_byte   (w_ser_byte),
    .o_last_c (w_last_byte)
  );

  assign rf_addr   = r_rf_addr;
  assign out_data  = w_ser_byte;
  assign out_valid = r_out_valid;
  assign hold_cpu  = r_hold_cpu;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full-range instance plus a FIRST_REG=2,
// NUM_REGS=4 instance, both reading a shared register file model.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset, start, start2, out_ready;
  logic [4:0]  rf_addr, rf_addr2;
  logic [31:0] rf_data, rf_data2;
  logic        hold_cpu, hold_cpu2, out_valid, out_valid2;
  logic        busy, busy2, done, done2;
  logic [7:0]  out_data, out_data2;

  logic [31:0] regs      [32];
  logic [31:0] exp_words [32];
  logic [7:0]  got       [256];
  logic [7:0]  exp_b     [256];
  logic [7:0]  lfsr = 8'hB5;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  always_comb rf_data  = (rf_addr  == 5'd0) ? 32'h0 : regs[rf_addr];
  always_comb rf_data2 = (rf_addr2 == 5'd0) ? 32'h0 : regs[rf_addr2];

  regfile_dump_reader dut (
    .clk(clk), .reset(reset), .start(start), .rf_addr(rf_addr), .rf_data(rf_data),
    .hold_cpu(hold_cpu), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  regfile_dump_reader #(.NUM_REGS(4), .FIRST_REG(2), .SYNC_BYTE(8'hA5)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .rf_addr(rf_addr2), .rf_data(rf_data2),
    .hold_cpu(hold_cpu2), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready), .busy(busy2), .done(done2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; start2 = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic clear_regs();
    for (int i = 0; i < 32; i++) begin
      regs[i]      = 32'h0;
      exp_words[i] = 32'h0;
    end
  endtask

  task automatic build_exp(input int first, input int last);
    int k;
    exp_b[0] = 8'hA5;
    k = 1;
    for (int r = first; r <= last; r++) begin
      for (int b = 0; b < 4; b++) begin
        exp_b[k] = exp_words[r][8*b +: 8];
        k++;
      end
    end
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) start = 1'b1; else start2 = 1'b1;
    step();
    start = 1'b0; start2 = 1'b0;
  endtask

  // Drives out_ready (mode 0: always, 1: LFSR, 2: always + start spam) and records accepted bytes
  task automatic collect(input int sel, input int mode, input int stop_at, input int max_cyc,
                         output int nb, output int nd, output int first_done,
                         output bit timeout, output int stab_err, output int hold_low);
    int         cyc;
    bit         have_prev;
    logic [7:0] prev;
    logic [7:0] d;
    logic       v, rdy, dn, hl;
    nb = 0; nd = 0; first_done = -1; timeout = 1'b0; stab_err = 0; hold_low = 0;
    cyc = 0; have_prev = 1'b0; prev = 8'h0;
    forever begin
      if (nb == stop_at) begin
        out_ready = 1'b0;
        break;
      end
      v = (sel != 0) ? out_valid2 : out_valid;
      d = (sel != 0) ? out_data2  : out_data;
      if (have_prev && v && (d !== prev)) stab_err++;
      rdy = 1'b1;
      if (mode == 1) begin
        rdy  = lfsr[0];
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
      if (mode == 2 && sel == 0)
        start = (first_done < 0) ? (cyc % 3 == 0) : (cyc == first_done);
      out_ready = rdy;
      if (v && rdy) begin
        got[nb] = d;
        nb++;
        have_prev = 1'b0;
      end else begin
        have_prev = v;
        prev      = d;
      end
      step();
      start = 1'b0;
      cyc++;
      dn = (sel != 0) ? done2 : done;
      hl = (sel != 0) ? hold_cpu2 : hold_cpu;
      if (dn) begin
        nd++;
        if (first_done < 0) first_done = cyc;
      end
      if (first_done < 0 && !hl) hold_low++;
      if (first_done >= 0 && cyc >= first_done + 4) break;
      if (cyc >= max_cyc) begin
        timeout = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (hold_cpu !== 1'b0) begin n_fail++; $display("FAIL reset_hold got %b exp 0", hold_cpu); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (rf_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", rf_addr); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", out_data); end
    n_checks++; if (rf_addr2 !== 5'd2) begin n_fail++; $display("FAIL reset_addr2 got %0d exp 2", rf_addr2); end
  endtask

  task automatic test_full_dump();
    int nb, nd, fd, se, hlow, bad;
    bit to;
    logic [7:0] hand [13];
    hand = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
             8'h00, 8'h40, 8'h00, 8'h00};
    clear_regs();
    regs[1] = 32'h11223344; exp_words[1] = 32'h11223344;
    regs[2] = 32'h00004000; exp_words[2] = 32'h00004000;
    build_exp(0, 31);
    pulse_start(0);
    n_checks++; if (hold_cpu !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL full_hold_busy got %b%b exp 11", hold_cpu, busy); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_fail++; $display("FAIL full_sync got v=%b %h exp v=1 a5", out_valid, out_data); end
    collect(0, 0, 1000, 1000, nb, nd, fd, to, se, hlow);
    n_checks++; if (to) begin n_fail++; $display("FAIL full_timeout got bytes=%0d exp done", nb); end
    n_checks++; if (nb !== 129) begin n_fail++; $display("FAIL full_count got %0d exp 129", nb); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL full_done_pulses got %0d exp 1", nd); end
    n_checks++; if (fd !== 161) begin n_fail++; $display("FAIL full_latency got %0d exp 161 edges after start", fd); end
    n_checks++; if (hlow !== 0) begin n_fail++; $display("FAIL full_hold_drop got %0d low cycles exp 0", hlow); end
    for (int i = 0; i < 13; i++) begin
      n_checks++;
      if (got[i] !== hand[i]) begin n_fail++; $display("FAIL full_head[%0d] got %h exp %h", i, got[i], hand[i]); end
    end
    bad = 0;
    for (int i = 0; i < 129; i++) if (got[i] !== exp_b[i]) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_stream got %0d wrong bytes exp 0", bad); end
    n_checks++; if (busy !== 1'b0 || hold_cpu !== 1'b0) begin n_fail++; $display("FAIL full_idle got busy=%b hold=%b exp 00", busy, hold_cpu); end
    n_checks++; if (rf_addr !== 5'd31) begin n_fail++; $display("FAIL full_last_addr got %0d exp 31", rf_addr); end
  endtask

  task automatic test_backpressure();
    int nb, nd, fd, se, hlow, bad;
    bit to;
    pulse_start(0);
    collect(0, 1, 1000, 3000, nb, nd, fd, to, se, hlow);
    n_checks++; if (to) begin n_fail++; $display("FAIL bp_timeout got bytes=%0d exp done", nb); end
    n_checks++; if (nb !== 129) begin n_fail++; $display("FAIL bp_count got %0d exp 129", nb); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL bp_done_pulses got %0d exp 1", nd); end
    n_checks++; if (se !== 0) begin n_fail++; $display("FAIL bp_stable got %0d changes exp 0", se); end
    n_checks++; if (fd <= 161) begin n_fail++; $display("FAIL bp_stalled got %0d edges exp >161", fd); end
    bad = 0;
    for (int i = 0; i < 129; i++) if (got[i] !== exp_b[i]) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_stream got %0d wrong bytes exp 0", bad); end
  endtask

  task automatic test_reset_mid();
    int nb, nd, fd, se, hlow, bad;
    bit to;
    regs[7] = 32'h77665544; exp_words[7] = 32'h77665544;
    build_exp(0, 31);
    pulse_start(0);
    collect(0, 0, 31, 1000, nb, nd, fd, to, se, hlow);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h66) begin n_fail++; $display("FAIL mid_pos got v=%b %h exp v=1 66", out_valid, out_data); end
    reset = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", busy); end
    n_checks++; if (hold_cpu !== 1'b0) begin n_fail++; $display("FAIL mid_hold got %b exp 0", hold_cpu); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done got %b exp 0", done); end
    reset = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_stays_idle got busy=%b done=%b exp 00", busy, done); end
    pulse_start(0);
    collect(0, 0, 1000, 1000, nb, nd, fd, to, se, hlow);
    n_checks++; if (nb !== 129 || nd !== 1) begin n_fail++; $display("FAIL mid_redump got bytes=%0d done=%0d exp 129 1", nb, nd); end
    n_checks++; if (got[0] !== 8'hA5) begin n_fail++; $display("FAIL mid_resync got %h exp a5", got[0]); end
    n_checks++; if (got[31] !== 8'h66) begin n_fail++; $display("FAIL mid_x7b2 got %h exp 66", got[31]); end
    bad = 0;
    for (int i = 0; i < 129; i++) if (got[i] !== exp_b[i]) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL mid_stream got %0d wrong bytes exp 0", bad); end
  endtask

  task automatic test_start_spam();
    int nb, nd, fd, se, hlow;
    bit to;
    pulse_start(0);
    collect(0, 2, 1000, 1000, nb, nd, fd, to, se, hlow);
    n_checks++; if (nb !== 129) begin n_fail++; $display("FAIL spam_count got %0d exp 129", nb); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL spam_done got %0d exp 1", nd); end
    n_checks++; if (fd !== 161) begin n_fail++; $display("FAIL spam_latency got %0d exp 161", fd); end
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL spam_queued got busy=%b valid=%b exp 00", busy, out_valid); end
  endtask

  task automatic test_subrange();
    int nb, nd, fd, se, hlow;
    bit to;
    logic [7:0] hand [9];
    hand = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h00, 8'h03, 8'h01, 8'hFE, 8'hCA};
    clear_regs();
    regs[2] = 32'h00004000;
    regs[3] = 32'hCAFE0103;
    pulse_start(1);
    collect(1, 0, 1000, 200, nb, nd, fd, to, se, hlow);
    n_checks++; if (nb !== 9) begin n_fail++; $display("FAIL sub_count got %0d exp 9", nb); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL sub_done got %0d exp 1", nd); end
    n_checks++; if (fd !== 11) begin n_fail++; $display("FAIL sub_latency got %0d exp 11", fd); end
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (got[i] !== hand[i]) begin n_fail++; $display("FAIL sub_byte[%0d] got %h exp %h", i, got[i], hand[i]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sub_main_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_hold_write();
    int nb, nd, fd, se, hlow;
    bit to;
    clear_regs();
    regs[1] = 32'h11223344;
    regs[2] = 32'h00004000;
    regs[5] = 32'h0505A0A0;
    pulse_start(0);
    out_ready = 1'b0;
    step();
    n_checks++; if (hold_cpu !== 1'b1) begin n_fail++; $display("FAIL hw_hold got %b exp 1", hold_cpu); end
    if (!hold_cpu) regs[5] = 32'hDEADBEEF;
    collect(0, 0, 1000, 1000, nb, nd, fd, to, se, hlow);
    n_checks++; if (nb !== 129 || nd !== 1) begin n_fail++; $display("FAIL hw_dump got bytes=%0d done=%0d exp 129 1", nb, nd); end
    n_checks++; if (got[0] !== 8'hA5) begin n_fail++; $display("FAIL hw_sync got %h exp a5", got[0]); end
    n_checks++;
    if ({got[24], got[23], got[22], got[21]} !== 32'h0505A0A0) begin
      n_fail++; $display("FAIL hw_x5 got %h%h%h%h exp 0505a0a0", got[24], got[23], got[22], got[21]);
    end
    n_checks++; if (hlow !== 0) begin n_fail++; $display("FAIL hw_hold_drop got %0d low cycles exp 0", hlow); end
    n_checks++; if (hold_cpu !== 1'b0) begin n_fail++; $display("FAIL hw_release got %b exp 0", hold_cpu); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'h0; exp_words[i] = 32'h0;
    end
    test_reset();
    test_full_dump();
    test_backpressure();
    test_reset_mid();
    test_start_spam();
    test_subrange();
    test_hold_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
